// File: rtl/ddr_dummy_pkg.sv
// Shared types and constants for the behavioural DDR2 line memory.
package ddr_dummy_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 28;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Ceiling log2, used to size the entry index and fill pointer.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_dummy_mem_if.sv
// Line request/response bus between a cache-side requester and the memory.
interface ddr_dummy_mem_if;
    import ddr_dummy_pkg::*;

    logic [LINE_W-1:0] mem_data_wr1;
    logic [LINE_W-1:0] mem_data_rd1;
    logic [ADDR_W-1:0] mem_data_addr1;
    logic              mem_rw_data1;
    logic              mem_valid_data1;
    logic              mem_ready_data1;

    modport master (
        output mem_data_wr1,
        output mem_data_addr1,
        output mem_rw_data1,
        output mem_valid_data1,
        input  mem_data_rd1,
        input  mem_ready_data1
    );

    modport slave (
        input  mem_data_wr1,
        input  mem_data_addr1,
        input  mem_rw_data1,
        input  mem_valid_data1,
        output mem_data_rd1,
        output mem_ready_data1
    );

endinterface

// File: rtl/ddr_dummy_cam.sv
// Fully-associative tag store: full-address tags, valid bits and a
// combinational lookup that reports the lowest matching entry.
module ddr_dummy_cam
    import ddr_dummy_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    input  logic              alloc_i,
    input  logic [IDX_W-1:0]  alloc_idx_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  hit_idx_o
);

    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;

    // Next valid vector: allocation marks the target entry valid.
    always_comb begin
        vld_d = vld_q;
        if (alloc_i) begin
            vld_d[alloc_idx_i] = 1'b1;
        end
    end

    // Valid bits are control state and are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Tags need no reset; an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc_i) begin
            tag_q[alloc_idx_i] <= lookup_addr_i;
        end
    end

    // Match and priority encode; scanning downward lets the lowest index win.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (tag_q[i] == lookup_addr_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ddr_dummy_mem.sv
// Behavioural DDR2 line memory: one 256-bit read or write per handshake,
// lookup and array update at the accept edge, single-cycle ready pulse
// after LATENCY wait cycles. FIFO replacement when the array is full.
module ddr_dummy_mem
    import ddr_dummy_pkg::*;
#(
    parameter int              LATENCY   = 4,
    parameter int              DEPTH     = 64,
    parameter logic [LINE_W-1:0] MISS_DATA = '0
) (
    input  logic            clk,
    input  logic            rst,
    ddr_dummy_mem_if.slave  bus,
    output logic            miss_err,
    output logic            busy
);

    localparam int IDX_W = clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              miss_q, miss_d;
    logic [LINE_W-1:0] rd_q, rd_d;
    logic [LINE_W-1:0] data_q [DEPTH];

    logic              accept;
    logic              wr_cmd;
    logic              rd_cmd;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              alloc;

    // A command is taken only in IDLE; WAIT and RESP ignore the bus entirely.
    // Lookup and update complete at the accept edge, so nothing about the
    // command has to be carried through WAIT.
    assign accept = !rst && (state_q == IDLE) && bus.mem_valid_data1;
    assign wr_cmd = accept && bus.mem_rw_data1;
    assign rd_cmd = accept && !bus.mem_rw_data1;
    assign alloc  = wr_cmd && !hit;

    ddr_dummy_cam #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_cam (
        .clk           (clk),
        .rst           (rst),
        .lookup_addr_i (bus.mem_data_addr1),
        .alloc_i       (alloc),
        .alloc_idx_i   (ptr_q),
        .hit_o         (hit),
        .hit_idx_o     (hit_idx)
    );

    // Next state, latency counter, fill pointer and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        miss_d  = miss_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Power-of-two depth makes the natural wrap the modulo.
        if (alloc) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
        // Read data register changes only on a read accept.
        if (rd_cmd) begin
            if (hit) begin
                rd_d = data_q[hit_idx];
            end else begin
                rd_d   = MISS_DATA;
                miss_d = 1'b1;
            end
        end
        ready_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // Control and output registers; reset also drops any pending ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            miss_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            miss_q  <= miss_d;
            rd_q    <= rd_d;
        end
    end

    // Line storage: write hit overwrites in place, write miss fills at the pointer.
    always_ff @(posedge clk) begin
        if (wr_cmd) begin
            if (hit) begin
                data_q[hit_idx] <= bus.mem_data_wr1;
            end else begin
                data_q[ptr_q] <= bus.mem_data_wr1;
            end
        end
    end

    assign bus.mem_data_rd1    = rd_q;
    assign bus.mem_ready_data1 = ready_q;
    assign miss_err            = miss_q;
    assign busy                = busy_q;

endmodule
